// File: rtl/execute_muldiv_unit.sv
// -----------------------------------------------------------------------------
// execute_muldiv_unit
//
// Multi-cycle RV32M multiply/divide unit sitting in the EX stage, fed directly
// by the ID/EX pipeline register. Multiplies use a radix-2 shift-add loop and
// divides a restoring shift-subtract loop, one step per clock over 32 clocks.
// Divide-by-zero and signed overflow take a fast path straight to DONE.
// While busy the unit stalls the front of the pipeline. The result is
// presented for one cycle, tagged with rd, to the EX/MEM register.
//
// Optional feature macro: MULDIV_SINGLE_CYCLE_MUL_EN
//   When defined, all multiplies are computed in the accept cycle by a
//   combinational 33x33 signed multiplier. They finish through the fast path.
//   When undefined, multiplies iterate and no hardware multiplier is inferred.
//
// Ports:
//   sys_clk_i    in   1     system clock, rising edge
//   rst_n_i      in   1     asynchronous active-low reset
//   start_i      in   1     ID/EX holds a valid M-extension instruction
//   op_i         in   3     RV32M funct3 (MUL..REMU)
//   rs1_rdata_i  in   XLEN  operand A (already forwarded)
//   rs2_rdata_i  in   XLEN  operand B (already forwarded)
//   rd_i         in   5     destination register
//   flush_i      in   1     branch/jump flush, aborts any operation
//   stall_o      out  1     freeze PC, IF/ID and ID/EX this cycle
//   valid_o      out  1     result_o/rd_o valid this cycle
//   result_o     out  XLEN  result
//   rd_o         out  5     destination tag of the result
// -----------------------------------------------------------------------------
module execute_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            sys_clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_rdata_i,
  input  logic [XLEN-1:0] rs2_rdata_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   b_abs;
  logic              neg_res;
  logic              neg_rem;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0]   a_abs_in, b_abs_in, fast_result;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_top, div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, calc_result;

  // Operand decode on the incoming instruction. MULH/DIV/REM are
  // signed x signed, and MULHSU is signed A x unsigned B. Magnitudes are
  // latched so that the loops only ever work on unsigned values.
  assign a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                    (op_i == OP_DIV)  || (op_i == OP_REM);
  assign b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign a_neg    = a_signed & rs1_rdata_i[XLEN-1];
  assign b_neg    = b_signed & rs2_rdata_i[XLEN-1];
  assign a_abs_in = a_neg ? -rs1_rdata_i : rs1_rdata_i;
  assign b_abs_in = b_neg ? -rs2_rdata_i : rs2_rdata_i;

  assign div_zero = op_i[2] && (rs2_rdata_i == '0);
  assign div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                    (rs1_rdata_i == MIN_INT) && (rs2_rdata_i == '1);
  assign accept   = (state == IDLE) && start_i && !flush_i;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  localparam int PW = 2 * XLEN;
  logic signed [XLEN:0] mul_a, mul_b;
  logic signed [PW-1:0] mul_p;

  // The 33-bit sign-extended operands cover all four multiply flavours with one
  // signed multiplier. Only the low 64 product bits are ever needed.
  assign mul_a = {a_signed & rs1_rdata_i[XLEN-1], rs1_rdata_i};
  assign mul_b = {b_signed & rs2_rdata_i[XLEN-1], rs2_rdata_i};
  assign mul_p = PW'(mul_a) * PW'(mul_b);
  assign fast  = div_zero | div_ovf | ~op_i[2];
`else
  assign fast  = div_zero | div_ovf;
`endif

  // Result for operations that bypass the iterative loop. A zero divisor
  // returns all ones for the quotient and A for the remainder. Signed
  // overflow returns MIN_INT for the quotient and zero for the remainder.
  always_comb begin
    fast_result = '0;
    if (div_zero) begin
      fast_result = op_i[1] ? rs1_rdata_i : '1;
    end else if (div_ovf) begin
      fast_result = op_i[1] ? '0 : MIN_INT;
    end
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    else begin
      fast_result = (op_i == OP_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
    end
`endif
  end

  // One radix-2 step. Multiply: acc holds {partial, multiplier}. Add B into
  // the upper half when the multiplier LSB is set, then shift right with the
  // carry. Divide: acc holds {remainder, quotient}. Shift left and subtract B
  // from the upper 33 bits. Keep the difference and set the quotient bit when
  // it does not borrow.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_abs} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_top   = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_top - {1'b0, b_abs};
    div_next  = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
  end

  // Sign correction and result selection applied to the final step.
  always_comb begin
    prod_fix    = neg_res ? -mul_next : mul_next;
    quo_fix     = neg_res ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    rem_fix     = neg_rem ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    calc_result = '0;
    case (op_q)
      OP_MUL:                       calc_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_result = quo_fix;
      OP_REM, OP_REMU:              calc_result = rem_fix;
      default:                      calc_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and stall. A flush overrides every transition. The stall drops
  // in DONE so that the pipeline advances together with the result.
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_o    = 1'b1;
          state_next = fast ? DONE : CALC;
        end
      end
      CALC: begin
        stall_o = 1'b1;
        if (cnt == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush_i) begin
      state_next = IDLE;
    end
  end

  // Datapath registers. Nothing is updated on a flush, so a flushed operation
  // never reaches result_o/rd_o. The outputs hold their last value until the
  // next completion.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      b_abs    <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc      <= '0;
      result_q <= '0;
      rd_out   <= '0;
    end else if (!flush_i) begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op_i;
            rd_q    <= rd_i;
            b_abs   <= b_abs_in;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            acc     <= {{XLEN{1'b0}}, a_abs_in};
            cnt     <= '0;
            if (fast) begin
              result_q <= fast_result;
              rd_out   <= rd_i;
            end
          end
        end
        CALC: begin
          acc <= step_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            result_q <= calc_result;
            rd_out   <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid_o  = (state == DONE);
  assign result_o = result_q;
  assign rd_o     = rd_out;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_execute_muldiv_unit
//
// Self-checking bench for execute_muldiv_unit. Expected results come from an
// arithmetic reference model built on 64-bit integers. Expected latency comes
// from the rule of one stall cycle for fast-path operations and 33 otherwise.
// The bench honours MULDIV_SINGLE_CYCLE_MUL_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_execute_muldiv_unit;

  logic        sys_clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_rdata_i;
  logic [31:0] rs2_rdata_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int errors = 0;
  int checks = 0;

  execute_muldiv_unit dut (
    .sys_clk_i   (sys_clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .rs1_rdata_i (rs1_rdata_i),
    .rs2_rdata_i (rs2_rdata_i),
    .rd_i        (rd_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .valid_o     (valid_o),
    .result_o    (result_o),
    .rd_o        (rd_o)
  );

  // 10 ns clock.
  always #5 sys_clk_i = ~sys_clk_i;

  // Reference model: RV32M results from plain 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Expected number of stall cycles before the result appears.
  function automatic int expectedStalls(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start_i     = 1'b1;
    flush_i     = 1'b0;
    op_i        = op;
    rs1_rdata_i = a;
    rs2_rdata_i = b;
    rd_i        = rd;
  endtask

  // Samples once per cycle, 1 ns after the falling edge, until valid_o is high
  // or the cycle budget runs out. Returns during the valid cycle.
  task automatic waitResult(output int stalls, output logic got, output logic stall_at_valid,
                            output logic [31:0] res, output logic [4:0] rdv);
    stalls = 0; got = 1'b0; stall_at_valid = 1'b0; res = '0; rdv = '0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (valid_o) begin
        got = 1'b1; stall_at_valid = stall_o; res = result_o; rdv = rd_o;
        break;
      end
      if (stall_o) stalls++;
      @(negedge sys_clk_i);
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    int stalls;
    logic got, sav;
    logic [31:0] res, expected;
    logic [4:0] rdv;
    expected = refModel(op, a, b);
    @(negedge sys_clk_i);
    applyStimulus(op, a, b, rd);
    waitResult(stalls, got, sav, res, rdv);
    checkOutput({tag, " valid seen"}, 32'(got), 32'd1);
    checkOutput({tag, " result"}, res, expected);
    checkOutput({tag, " rd"}, 32'(rdv), 32'(rd));
    checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(expectedStalls(op, a, b)));
    checkOutput({tag, " stall low at valid"}, 32'(sav), 32'd0);
    @(negedge sys_clk_i);
    start_i = 1'b0;
    #1;
    checkOutput({tag, " valid one cycle"}, 32'(valid_o), 32'd0);
    checkOutput({tag, " result held"}, result_o, expected);
  endtask

  initial begin
    int stalls;
    int vcount;
    logic got, sav;
    logic [31:0] res, ra, rb;
    logic [4:0] rdv;
    logic [2:0] rop;

    rst_n_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; rs1_rdata_i = '0; rs2_rdata_i = '0; rd_i = '0;

    // Reset state.
    @(negedge sys_clk_i);
    #1;
    checkOutput("reset stall", 32'(stall_o), 32'd0);
    checkOutput("reset valid", 32'(valid_o), 32'd0);
    checkOutput("reset result", result_o, 32'd0);
    checkOutput("reset rd", 32'(rd_o), 32'd0);
    @(negedge sys_clk_i);
    rst_n_i = 1'b1;

    // Idle with no start: neither stall nor valid.
    vcount = 0;
    repeat (5) begin
      @(negedge sys_clk_i);
      #1;
      if (valid_o || stall_o) vcount++;
    end
    checkOutput("idle quiet", 32'(vcount), 32'd0);

    // Directed operations.
    runOp("MUL 7*-3",        3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5);
    runOp("MULHU -1*-1",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    runOp("MULH -1*-1",      3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    runOp("MULHSU",          3'd2, 32'hFFFF_FFFE, 32'h8000_0001, 5'd8);
    runOp("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd10);
    runOp("REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11);
    runOp("DIVU 100/7",      3'd5, 32'd100, 32'd7, 5'd12);
    runOp("REMU 100/7",      3'd7, 32'd100, 32'd7, 5'd13);
    runOp("DIV by zero",     3'd4, 32'h0000_1234, 32'd0, 5'd14);
    runOp("REMU by zero",    3'd7, 32'h0000_1234, 32'd0, 5'd15);
    runOp("DIV overflow",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    runOp("REM overflow",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
    runOp("DIV rd0",         3'd4, 32'd1000, 32'hFFFF_FFF6, 5'd0);

    // Randomized operations, biased towards the special cases.
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 5'($urandom_range(0, 31)));
    end

    // Flush at CALC cycle 10: back to idle, stall drops, no result.
    @(negedge sys_clk_i);
    applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3);
    repeat (11) @(negedge sys_clk_i);
    flush_i = 1'b1;
    start_i = 1'b0;
    #1;
    checkOutput("flush stall in calc", 32'(stall_o), 32'd1);
    @(negedge sys_clk_i);
    flush_i = 1'b0;
    #1;
    checkOutput("flush stall dropped", 32'(stall_o), 32'd0);
    vcount = 0;
    repeat (40) begin
      @(negedge sys_clk_i);
      #1;
      if (valid_o) vcount++;
    end
    checkOutput("flush no valid", 32'(vcount), 32'd0);

    // Flush has priority over start in IDLE.
    @(negedge sys_clk_i);
    applyStimulus(3'd5, 32'd50, 32'd5, 5'd4);
    flush_i = 1'b1;
    #1;
    checkOutput("flush beats start stall", 32'(stall_o), 32'd0);
    @(negedge sys_clk_i);
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    checkOutput("flush beats start idle", 32'(stall_o | valid_o), 32'd0);

    // Start changes while busy: ignored until IDLE, then accepted.
    @(negedge sys_clk_i);
    applyStimulus(3'd5, 32'd100, 32'd7, 5'd9);
    repeat (6) @(negedge sys_clk_i);
    applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd12);
    waitResult(stalls, got, sav, res, rdv);
    checkOutput("busy first valid", 32'(got), 32'd1);
    checkOutput("busy first result", res, 32'd14);
    checkOutput("busy first rd", 32'(rdv), 32'd9);
    @(negedge sys_clk_i);
    waitResult(stalls, got, sav, res, rdv);
    checkOutput("busy second valid", 32'(got), 32'd1);
    checkOutput("busy second result", res, 32'hFFFF_FFFF);
    checkOutput("busy second rd", 32'(rdv), 32'd12);
    checkOutput("busy second stalls", 32'(stalls), 32'd33);
    @(negedge sys_clk_i);
    start_i = 1'b0;

    // Asynchronous reset in mid-operation clears outputs at once.
    @(negedge sys_clk_i);
    applyStimulus(3'd5, 32'd1000, 32'd3, 5'd21);
    repeat (5) @(negedge sys_clk_i);
    start_i = 1'b0;
    #2;
    rst_n_i = 1'b0;
    #1;
    checkOutput("async reset stall", 32'(stall_o), 32'd0);
    checkOutput("async reset valid", 32'(valid_o), 32'd0);
    checkOutput("async reset result", result_o, 32'd0);
    checkOutput("async reset rd", 32'(rd_o), 32'd0);
    @(negedge sys_clk_i);
    rst_n_i = 1'b1;

    // The unit still works after the reset.
    runOp("post reset DIVU", 3'd5, 32'd1000, 32'd3, 5'd21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
